// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the mul/div engine.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// One bit per cycle: shift-add multiply, restoring divide, both on magnitudes;
// signs are re-applied in a single FIX cycle before HI/LO are written.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder (follows dividend)
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] mq;        // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] mcand;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;

  // operand magnitudes and sign bookkeeping at accept time
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  // iteration datapath
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // operand conditioning, one iteration step, and final sign correction
  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    mul_sum   = mq[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
    div_sh    = {acc, mq[WIDTH-1]};
    div_ge    = div_sh >= {1'b0, mcand};
    div_diff  = div_sh - {1'b0, mcand};

    prod      = {acc, mq};
    prod_fix  = neg_q ? -prod : prod;
    q_fix     = neg_q ? -mq : mq;
    r_fix     = neg_r ? -acc : acc;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state; RUN exits on the edge where cnt steps from 1 to 0
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // datapath, HI/LO and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            // a start in the same cycle as a move wins; the move is dropped
            cnt    <= CNT_INIT;
            is_div <= bus.op[1];
            // divide by zero keeps the all-ones quotient unsigned-looking
            neg_q  <= (a_neg ^ b_neg) & ~(bus.op[1] & (bus.b == '0));
            neg_r  <= a_neg;
            acc    <= '0;
            mq     <= a_mag;
            mcand  <= b_mag;
          end else begin
            if (bus.mthi) hi_reg <= bus.wdata;
            if (bus.mtlo) lo_reg <= bus.wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            acc <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi_reg <= r_fix;
            lo_reg <= q_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and the
// accept-edge cycle; a monitor pops on every done pulse and checks values and latency.
module tb_mul_div_unit;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t q[$];

  mul_div_unit_if #(.WIDTH(32)) m();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(m));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] hi_e, input logic [31:0] lo_e, input string nm);
    exp_t e;
    m.start = 1'b1; m.op = op; m.a = a; m.b = b;
    e.hi = hi_e; e.lo = lo_e; e.e0 = cyc + 1; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
    m.start = 1'b0; m.mthi = 1'b0; m.mtlo = 1'b0;
  endtask

  // returns at the negedge of the done cycle
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m.busy) return;
    end
    errs++; vecs++;
    $display("FAIL wait_idle: busy still 1 after 200 cycles, expected 0");
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && m.done) begin
      if (q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL spurious_done: done=1 with no operation outstanding, expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_hi"}, m.hi, e.hi);
        chk({e.nm, "_lo"}, m.lo, e.lo);
        chk({e.nm, "_lat"}, 32'(cyc - e.e0), 32'd33);
      end
    end
  end

  initial begin
    m.start = 0; m.op = 0; m.a = 0; m.b = 0; m.mthi = 0; m.mtlo = 0; m.wdata = 0;
    #12;
    chk("rst_busy", 32'(m.busy), 0);
    chk("rst_done", 32'(m.done), 0);
    chk("rst_hi", m.hi, 0);
    chk("rst_lo", m.lo, 0);
    @(negedge clk); rst = 1'b0;

    go(MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7_m3"); wait_idle();
    go(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"); wait_idle();
    go(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");  wait_idle();
    go(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"); wait_idle();
    go(DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, "divu_by0");  wait_idle();
    go(DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_ovf");   wait_idle();
    go(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2");  wait_idle();
    go(DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"); wait_idle();
    go(MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30,       "mult_m5_m6"); wait_idle();
    go(MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0,        "multu_msb"); wait_idle();

    // start and moves during a run are ignored; HI/LO hold the old result
    go(MULT, 32'h12345678, 32'h100, 32'h12, 32'h34567800, "mult_busy");
    repeat (9) @(negedge clk);
    chk("run_busy", 32'(m.busy), 1);
    chk("run_hold_hi", m.hi, 32'd1);
    chk("run_hold_lo", m.lo, 32'd0);
    m.start = 1; m.op = MULTU; m.a = 1; m.b = 1; m.mthi = 1; m.mtlo = 1; m.wdata = 32'hDEADBEEF;
    @(negedge clk);
    m.start = 0; m.mthi = 0; m.mtlo = 0;
    wait_idle();
    @(negedge clk);

    // moves in IDLE
    m.mthi = 1; m.wdata = 32'hA5A5A5A5;
    @(negedge clk); m.mthi = 0;
    chk("mthi_hi", m.hi, 32'hA5A5A5A5);
    chk("mthi_lo_kept", m.lo, 32'h34567800);
    m.mthi = 1; m.mtlo = 1; m.wdata = 32'h5A5A5A5A;
    @(negedge clk); m.mthi = 0; m.mtlo = 0;
    chk("mtboth_hi", m.hi, 32'h5A5A5A5A);
    chk("mtboth_lo", m.lo, 32'h5A5A5A5A);

    // start with a move in the same cycle: start wins, move dropped
    m.mthi = 1; m.wdata = 32'hFFFF0000;
    go(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "start_vs_mthi");
    chk("drop_mthi_hi", m.hi, 32'h5A5A5A5A);
    wait_idle();

    // reset mid-divide aborts without writing HI/LO
    go(DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, "div_aborted");
    repeat (19) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(m.busy), 0);
    chk("abort_hi", m.hi, 0);
    chk("abort_lo", m.lo, 0);
    void'(q.pop_back());
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    go(DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, "div_after_rst"); wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
